// File: rtl/pipeline_defs.sv
// -----------------------------------------------------------------------------
// pipeline_defs
// Shared definitions for the program loader: default parameter values, the
// load terminator word and the loader FSM state encoding.
//
// Configuration macro: LOADER_CHECKSUM_EN adds the CHECK state to the
// encoding; without it the state does not exist.
// -----------------------------------------------------------------------------
package pipeline_defs;

   localparam int          ADDR_W_DEF     = 11;        // matches the 11-bit PC
   localparam logic [7:0]  START_BYTE_DEF = 8'hA5;     // begins a load
   localparam logic [7:0]  STOP_BYTE_DEF  = 8'h5A;     // halts the pipeline
   localparam logic [31:0] TERMINATOR     = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK,
`endif
      ST_RUN,
      ST_ERR
   } state_t;

endpackage

// File: rtl/word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Packs a stream of bytes into 32-bit words, big-endian (first byte lands in
// [31:24]). The completed word and its strobe are presented combinationally in
// the cycle the fourth byte arrives, so the consumer can register the write
// and have it appear exactly one cycle later.
//
// Configuration macro: LOADER_CHECKSUM_EN (not used in this file).
//
// Ports
//   clock      system clock, rising edge
//   reset      asynchronous, active-high
//   clear      synchronous restart of the byte index (new load)
//   enable     accept bytes only while high (LOAD state)
//   rx_data    received byte
//   rx_valid   one-cycle strobe qualifying rx_data
//   word       assembled word; valid when word_done is high
//   word_done  high in the cycle the fourth byte of a word is accepted
// -----------------------------------------------------------------------------
module word_assembler (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        enable,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [31:0] word,
   output logic        word_done
);

   logic [1:0]  byte_idx;
   logic [23:0] shift;

   // NOTE: non-blocking assignments so both registers see pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         byte_idx <= 2'd0;
         shift    <= 24'd0;
      end else if (clear) begin
         byte_idx <= 2'd0;
         shift    <= 24'd0;
      end else if (enable && rx_valid) begin
         shift    <= {shift[15:0], rx_data};
         byte_idx <= byte_idx + 2'd1;
      end
   end

   // The fourth byte is appended on the fly rather than waiting a cycle.
   assign word      = {shift, rx_data};
   assign word_done = enable && rx_valid && (byte_idx == 2'd3);

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Loads a program received over UART into instruction memory, then releases
// the pipeline. A START_BYTE opens a load; bytes are packed into big-endian
// words and written at consecutive addresses until the all-ones terminator
// word. STOP_BYTE while running halts the pipeline and returns to IDLE.
// Overflowing the memory goes to ERR, from which a START_BYTE restarts.
//
// Configuration macro: LOADER_CHECKSUM_EN -- when defined, a running XOR of
// every byte after START_BYTE (terminator included) is kept and the byte after
// the terminator must match it (CHECK state) before the pipeline runs.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-high
//   rx_data      received UART byte
//   rx_valid     one-cycle strobe qualifying rx_data
//   imem_we      instruction-memory write strobe (one cycle per word)
//   imem_addr    instruction-memory word address
//   imem_wdata   instruction word to write
//   pipe_enable  high only while running
//   busy         high while loading (and checking)
//   error        high in ERR
//   word_count   words written by the last or current load
// -----------------------------------------------------------------------------
module program_loader
   import pipeline_defs::*;
#(
   parameter int         ADDR_W     = ADDR_W_DEF,
   parameter logic [7:0] START_BYTE = START_BYTE_DEF,
   parameter logic [7:0] STOP_BYTE  = STOP_BYTE_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              pipe_enable,
   output logic              busy,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

   state_t      state;
   logic [31:0] word;
   logic        word_done;
   logic        start_hit;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  checksum;
`endif

   // A load can be opened from IDLE or ERR only.
   assign start_hit = rx_valid && (rx_data == START_BYTE) &&
                      ((state == ST_IDLE) || (state == ST_ERR));

   word_assembler u_assembler (
      .clock     (clock),
      .reset     (reset),
      .clear     (start_hit),
      .enable    (state == ST_LOAD),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .word      (word),
      .word_done (word_done)
   );

   // word_count doubles as the address counter: the next write address is
   // always the number of words already written, so it can never wrap.
   // NOTE: only control registers are reset; the instruction memory is
   // external and keeps its contents across reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         pipe_enable <= 1'b0;
         busy        <= 1'b0;
         error       <= 1'b0;
         word_count  <= '0;
`ifdef LOADER_CHECKSUM_EN
         checksum    <= 8'd0;
`endif
      end else begin
         imem_we <= 1'b0;
         case (state)
            ST_IDLE, ST_ERR: begin
               if (start_hit) begin
                  state       <= ST_LOAD;
                  imem_addr   <= '0;
                  word_count  <= '0;
                  busy        <= 1'b1;
                  error       <= 1'b0;
                  pipe_enable <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                  checksum    <= 8'd0;
`endif
               end
            end

            ST_LOAD: begin
`ifdef LOADER_CHECKSUM_EN
               if (rx_valid) checksum <= checksum ^ rx_data;
`endif
               if (word_done) begin
                  if (word == TERMINATOR) begin
`ifdef LOADER_CHECKSUM_EN
                     state       <= ST_CHECK;
`else
                     state       <= ST_RUN;
                     pipe_enable <= 1'b1;
                     busy        <= 1'b0;
`endif
                  end else if (word_count == MAX_WORDS) begin
                     state <= ST_ERR;
                     error <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     imem_we    <= 1'b1;
                     imem_addr  <= word_count[ADDR_W-1:0];
                     imem_wdata <= word;
                     word_count <= word_count + 1'b1;
                  end
               end
            end

`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
               if (rx_valid) begin
                  busy <= 1'b0;
                  if (rx_data == checksum) begin
                     state       <= ST_RUN;
                     pipe_enable <= 1'b1;
                  end else begin
                     state <= ST_ERR;
                     error <= 1'b1;
                  end
               end
            end
`endif

            ST_RUN: begin
               if (rx_valid && (rx_data == STOP_BYTE)) begin
                  state       <= ST_IDLE;
                  pipe_enable <= 1'b0;
               end
            end

            // NOTE: unused encodings fall back to IDLE so a corrupted state
            // register cannot leave the loader stuck.
            default: begin
               state       <= ST_IDLE;
               pipe_enable <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
// Self-checking bench for program_loader. A byte-level model of the loader's
// documented behaviour predicts every output each cycle; directed streams
// exercise loading, run/stop, overflow, mid-load reset and (with
// LOADER_CHECKSUM_EN) checksum acceptance/rejection. Literal expectations pin
// the headline results.
// -----------------------------------------------------------------------------
module tb_program_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        imem_we;
   logic [10:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        pipe_enable;
   logic        busy;
   logic        error;
   logic [11:0] word_count;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   program_loader dut (
      .clock       (clock),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .imem_we     (imem_we),
      .imem_addr   (imem_addr),
      .imem_wdata  (imem_wdata),
      .pipe_enable (pipe_enable),
      .busy        (busy),
      .error       (error),
      .word_count  (word_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_LOAD, M_CHECK, M_RUN, M_ERR} mode_e;
   mode_e       m_mode;
   logic [7:0]  bq [0:2];      // bytes of the word in progress
   int          bn;            // how many bytes collected so far
   logic [7:0]  m_xor;
   logic        exp_we, exp_pe, exp_busy, exp_err;
   logic [10:0] exp_addr;
   logic [31:0] exp_wdata;
   logic [11:0] exp_wc;
   wire  [31:0] m_word = {bq[0], bq[1], bq[2], rx_data};

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_mode <= M_IDLE; bn <= 0; m_xor <= 8'd0;
         exp_we <= 1'b0; exp_addr <= '0; exp_wdata <= '0;
         exp_pe <= 1'b0; exp_busy <= 1'b0; exp_err <= 1'b0; exp_wc <= '0;
      end else begin
         exp_we <= 1'b0;
         if (rx_valid) begin
            case (m_mode)
               M_IDLE, M_ERR: if (rx_data == 8'hA5) begin
                  m_mode <= M_LOAD; bn <= 0; m_xor <= 8'd0;
                  exp_addr <= '0; exp_wc <= '0;
                  exp_busy <= 1'b1; exp_err <= 1'b0; exp_pe <= 1'b0;
               end
               M_LOAD: begin
                  m_xor <= m_xor ^ rx_data;
                  if (bn < 3) begin
                     bq[bn] <= rx_data;
                     bn     <= bn + 1;
                  end else begin
                     bn <= 0;
                     if (m_word == 32'hFFFF_FFFF) begin
`ifdef LOADER_CHECKSUM_EN
                        m_mode <= M_CHECK;
`else
                        m_mode <= M_RUN; exp_pe <= 1'b1; exp_busy <= 1'b0;
`endif
                     end else if (exp_wc == 12'd2048) begin
                        m_mode <= M_ERR; exp_err <= 1'b1; exp_busy <= 1'b0;
                     end else begin
                        exp_we <= 1'b1; exp_addr <= exp_wc[10:0];
                        exp_wdata <= m_word; exp_wc <= exp_wc + 12'd1;
                     end
                  end
               end
               M_CHECK: begin
                  exp_busy <= 1'b0;
                  if (rx_data == m_xor) begin m_mode <= M_RUN; exp_pe <= 1'b1; end
                  else begin m_mode <= M_ERR; exp_err <= 1'b1; end
               end
               M_RUN: if (rx_data == 8'h5A) begin
                  m_mode <= M_IDLE; exp_pe <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   // ---------------- compare process + write log ----------------
   logic [10:0] log_addr [$];
   logic [31:0] log_data [$];

   always @(posedge clock) begin
      #1;
      if (imem_we) begin
         log_addr.push_back(imem_addr);
         log_data.push_back(imem_wdata);
      end
      if (cmp_en) begin
         check("imem_we",     imem_we,     exp_we);
         check("imem_addr",   imem_addr,   exp_addr);
         check("imem_wdata",  imem_wdata,  exp_wdata);
         check("pipe_enable", pipe_enable, exp_pe);
         check("busy",        busy,        exp_busy);
         check("error",       error,       exp_err);
         check("word_count",  word_count,  exp_wc);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_byte(input logic [7:0] b, input int gap = 0);
      @(negedge clock);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clock);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clock);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap = 0);
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      #1 reset = 1'b1;
      cmp_en = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(1);

      // Reset values
      check("rst imem_we", imem_we, 0);
      check("rst imem_addr", imem_addr, 0);
      check("rst imem_wdata", imem_wdata, 0);
      check("rst pipe_enable", pipe_enable, 0);
      check("rst busy", busy, 0);
      check("rst error", error, 0);
      check("rst word_count", word_count, 0);

      // Non-start bytes in IDLE are ignored
      send_byte(8'h12);
      send_byte(8'h5A);
      check("idle ignore busy", busy, 0);

      // Basic two-word program
      clear_log();
      send_byte(8'hA5, 1);
      check("start busy", busy, 1);
      check("start word_count", word_count, 0);
      send_word(32'h0000_0020, 1);
      send_word(32'h8C01_0004, 1);
      send_word(32'hFFFF_FFFF, 1);
      idle(2);
`ifdef LOADER_CHECKSUM_EN
      check("check busy", busy, 1);
      check("check pipe_enable", pipe_enable, 0);
      send_byte(8'hA9);           // 20^8C^01^04 = A9
`endif
      check("prog pipe_enable", pipe_enable, 1);
      check("prog word_count", word_count, 2);
      check("prog writes", log_data.size(), 2);
      if (log_data.size() == 2) begin
         check("prog addr0", log_addr[0], 0);
         check("prog data0", log_data[0], 32'h0000_0020);
         check("prog addr1", log_addr[1], 1);
         check("prog data1", log_data[1], 32'h8C01_0004);
      end

      // Stop from RUN, then a stray byte is ignored
      send_byte(8'h5A);
      check("stop pipe_enable", pipe_enable, 0);
      check("stop busy", busy, 0);
      send_byte(8'h12);
      idle(2);
      check("after stop pipe_enable", pipe_enable, 0);
      check("after stop word_count", word_count, 2);

      // START/STOP values inside a load are plain data
      clear_log();
      send_byte(8'hA5);
      send_word(32'hA55A_0001, 2);
      send_word(32'h5AA5_0000);
      send_word(32'hFFFF_FFFF);
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'h01);           // FE ^ FF ^ 00 = 01
`endif
      idle(2);
      check("data writes", log_data.size(), 2);
      if (log_data.size() == 2) begin
         check("data word0", log_data[0], 32'hA55A_0001);
         check("data word1", log_data[1], 32'h5AA5_0000);
      end
      check("data pipe_enable", pipe_enable, 1);
      send_byte(8'h5A);

      // Reset mid-load discards the partial word
      clear_log();
      send_byte(8'hA5);
      send_byte(8'h11);
      send_byte(8'h22);
      @(negedge clock);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(1);
      check("midrst writes", log_data.size(), 0);
      check("midrst busy", busy, 0);
      check("midrst word_count", word_count, 0);
      check("midrst imem_addr", imem_addr, 0);
      send_byte(8'hA5);
      send_word(32'h3344_5566, 1);
      send_word(32'hFFFF_FFFF);
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'h44);
`endif
      idle(2);
      check("midrst reload writes", log_data.size(), 1);
      if (log_data.size() == 1) check("midrst reload data", log_data[0], 32'h3344_5566);
      check("midrst reload pipe_enable", pipe_enable, 1);
      send_byte(8'h5A);

      // Fill all 2048 words, then overflow
      clear_log();
      send_byte(8'hA5);
      for (int i = 0; i < 2048; i++) send_word(32'h0100_0000 + i);
      idle(2);
      check("full writes", log_data.size(), 2048);
      if (log_data.size() == 2048) begin
         check("full last addr", log_addr[2047], 2047);
         check("full last data", log_data[2047], 32'h0100_07FF);
      end
      check("full word_count", word_count, 2048);
      check("full busy", busy, 1);
      send_word(32'h1234_5678);
      idle(2);
      check("ovf error", error, 1);
      check("ovf writes", log_data.size(), 2048);
      check("ovf pipe_enable", pipe_enable, 0);
      check("ovf busy", busy, 0);
      send_byte(8'hA5);
      check("restart busy", busy, 1);
      check("restart error", error, 0);
      check("restart word_count", word_count, 0);
      send_word(32'hFFFF_FFFF);
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'h00);
`endif
      idle(1);
      check("restart pipe_enable", pipe_enable, 1);
      send_byte(8'h5A);

`ifdef LOADER_CHECKSUM_EN
      // Good checksum runs, bad checksum errors, restart afterwards
      send_byte(8'hA5);
      send_word(32'h0102_0304);
      send_word(32'hFFFF_FFFF);
      send_byte(8'h04);
      check("cks good pipe_enable", pipe_enable, 1);
      check("cks good error", error, 0);
      send_byte(8'h5A);
      send_byte(8'hA5);
      send_word(32'h0102_0304);
      send_word(32'hFFFF_FFFF);
      send_byte(8'h05);
      check("cks bad error", error, 1);
      check("cks bad pipe_enable", pipe_enable, 0);
      send_byte(8'hA5);
      check("cks restart busy", busy, 1);
      check("cks restart word_count", word_count, 0);
`endif

      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning the instruction-memory word-address width (matches the 11-bit PC).
REQ-002 SHALL have parameter START_BYTE, default 8'hA5, meaning the byte that begins a load.
REQ-003 SHALL have parameter STOP_BYTE, default 8'h5A, meaning the byte that halts the running pipeline.
REQ-004 SHALL have port clock, input, 1, the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port rx_data, input, 8, the received UART byte.
REQ-007 SHALL have port rx_valid, input, 1, a one-cycle strobe marking rx_data valid; at most one byte per cycle.
REQ-008 SHALL have port imem_we, output, 1, the instruction-memory write strobe.
REQ-009 SHALL have port imem_addr, output, ADDR_W, the instruction-memory word address.
REQ-010 SHALL have port imem_wdata, output, 32, the instruction word to write.
REQ-011 SHALL have port pipe_enable, output, 1, high while the pipeline is allowed to advance.
REQ-012 SHALL have port busy, output, 1, high in LOAD (and CHECK when compiled in).
REQ-013 SHALL have port error, output, 1, high in ERR.
REQ-014 SHALL have port word_count, output, ADDR_W+1, the number of words written by the last or current load.

Function
REQ-015 SHALL implement states IDLE, LOAD, CHECK (macro only), RUN and ERR.
REQ-016 In IDLE, a START_BYTE SHALL move to LOAD, clear the address, byte index, word_count and checksum; other bytes SHALL be ignored.
REQ-017 In LOAD, bytes SHALL be assembled big-endian (first byte to [31:24]) using a 2-bit byte index.
REQ-018 A completed word SHALL pulse imem_we for exactly one cycle, the cycle after the fourth byte's rx_valid, with imem_addr equal to the current address; then the address and word_count SHALL increment.
REQ-019 A completed word of 32'hFFFFFFFF SHALL be the terminator: it is not written, and the block moves to RUN (or CHECK).
REQ-020 A completed non-terminator word arriving when word_count == 2**ADDR_W SHALL not be written and SHALL move the block to ERR; imem_addr SHALL never wrap.
REQ-021 In RUN, pipe_enable SHALL be 1; a STOP_BYTE SHALL drop pipe_enable the next cycle and move to IDLE; other bytes SHALL be ignored.
REQ-022 In ERR, pipe_enable SHALL be 0; a START_BYTE SHALL restart exactly as from IDLE.
REQ-023 pipe_enable SHALL be 0 in every state except RUN.
REQ-024 Within LOAD, START_BYTE and STOP_BYTE values SHALL be treated as ordinary data.

Reset
REQ-025 Reset SHALL force IDLE and set imem_we=0, imem_addr=0, imem_wdata=0, pipe_enable=0, busy=0, error=0 and word_count=0.
REQ-026 Reset mid-load SHALL discard any partial word; no imem_we SHALL be issued for it, and memory contents already written are untouched.

Configuration
REQ-027 Macro LOADER_CHECKSUM_EN, when defined, SHALL maintain a running XOR of all bytes after START_BYTE up to and including the terminator; after the terminator the block SHALL enter CHECK, and the next byte SHALL move it to RUN if it equals the XOR, else to ERR.
REQ-028 Without LOADER_CHECKSUM_EN, the CHECK state and the checksum register SHALL be absent, and the terminator SHALL go directly to RUN.

Structure
REQ-029 The state encoding, START_BYTE/STOP_BYTE defaults, the terminator constant and the ADDR_W default SHALL live in the shared package pipeline_defs.
REQ-030 Byte-to-word assembly (byte index, shift register, word-complete strobe) SHALL be a sub-module named word_assembler; the FSM, address counter and checksum stay in program_loader.

Verification
REQ-031 Byte sequence A5, 00 00 00 20, 8C 01 00 04, FF FF FF FF SHALL produce:
- imem_we pulses at addr 0 (data 32'h00000020) and addr 1 (data 32'h8C010004);
- word_count=2;
- pipe_enable=1.
REQ-032 In RUN, byte 5A SHALL make pipe_enable=0 the next cycle and return the block to IDLE; a following 12 SHALL be ignored.
REQ-033 After A5, 2048 non-terminator words SHALL be written at addresses 0..2047; a 2049th word SHALL give error=1, no imem_we, and pipe_enable=0.
REQ-034 Reset asserted after A5, 11 22 SHALL produce no imem_we, IDLE, and all outputs zero.
REQ-035 With LOADER_CHECKSUM_EN defined:
- A5, 01 02 03 04, FF FF FF FF, checksum 04 SHALL end in RUN;
- the same stream with checksum 05 SHALL give error=1;
- a following A5 SHALL give busy=1 and word_count=0.
